pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage integer pipeline. Drives the
//   IF/ID, ID/EX, EX/MEM and MEM/WB latch enables and flushes plus the PC enable,
//   resolving load-use hazards, taken-branch squashes, data-memory wait states
//   and multi-cycle EX operations. Keeps stall/flush counters and a stall watchdog.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   id_rs1/id_rs2            source registers of the instruction in ID
//   id_uses_rs1/id_uses_rs2  ID instruction actually reads that source
//   ex_rd, ex_is_load        destination and load flag of the instruction in EX
//   ex_branch_taken          EX resolved a taken branch/jump
//   ex_mc_busy               multi-cycle EX unit still working
//   mem_busy                 data memory wait state
//   pc_en, *_en              PC and pipeline latch enables (combinational)
//   *_flush                  latch flushes, applied at the next edge (combinational)
//   stall_timeout            watchdog flag (registered)
//   stall_cycles             cycles with pc_en=0, wraps
//   flush_count              taken-branch squashes, wraps
module pipeline_hazard_ctrl #(
   parameter int unsigned STALL_LIMIT = 256,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_branch_taken,
   input  logic             ex_mc_busy,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             stall_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [1:0] RUN        = 2'd0;
   localparam logic [1:0] MEM_FREEZE = 2'd1;
   localparam logic [1:0] EX_HOLD    = 2'd2;

   localparam int unsigned     WD_W   = $clog2(STALL_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_LIMIT);

   logic [1:0]       state;
   logic             load_use;
   logic             squash;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [CNT_W-1:0] stall_q, flush_q;

   // Every state is entered purely by priority of the current inputs (a freeze
   // ends into whatever the inputs select that same cycle), so the state of a
   // cycle is a decode of its inputs and needs no register of its own.
   always_comb begin
      if (mem_busy) begin
         state = MEM_FREEZE;
      end else if (ex_mc_busy) begin
         state = EX_HOLD;
      end else begin
         state = RUN;
      end
   end

   // x0 never carries a real dependency.
   assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   // A frozen EX keeps its branch, so it is acted on only once back in RUN.
   assign squash = (state == RUN) && ex_branch_taken;

   always_comb begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      if (!rst) begin
         case (state)
            MEM_FREEZE: begin
               // everything holds
            end
            EX_HOLD: begin
               // Front end holds; a bubble drains into MEM behind the busy op.
               ex_mem_en    = 1'b1;
               ex_mem_flush = 1'b1;
               mem_wb_en    = 1'b1;
            end
            default: begin
               ex_mem_en = 1'b1;
               mem_wb_en = 1'b1;
               if (ex_branch_taken) begin
                  // ID is squashed, so any load-use against it is moot.
                  pc_en       = 1'b1;
                  if_id_en    = 1'b1;
                  id_ex_en    = 1'b1;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (load_use) begin
                  // Hold IF/ID, push a bubble into EX; clears next cycle.
                  id_ex_en    = 1'b1;
                  id_ex_flush = 1'b1;
               end else begin
                  pc_en    = 1'b1;
                  if_id_en = 1'b1;
                  id_ex_en = 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      if (state == RUN) begin
         wd_d = '0;
      end else if (wd_q == WD_MAX) begin
         wd_d = wd_q;
      end else begin
         wd_d = wd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
         wd_q    <= '0;
      end else begin
         if (!pc_en) begin
            stall_q <= stall_q + 1'b1;
         end
         if (squash) begin
            flush_q <= flush_q + 1'b1;
         end
         wd_q <= wd_d;
      end
   end

   assign stall_timeout = (wd_q == WD_MAX);
   assign stall_cycles  = stall_q;
   assign flush_count   = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
   localparam int LIMIT = 8;
   localparam int CW    = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    id_rs1, id_rs2, ex_rd;
   logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken, ex_mc_busy, mem_busy;
   logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic          if_id_flush, id_ex_flush, ex_mem_flush, stall_timeout;
   logic [CW-1:0] stall_cycles, flush_count;
   logic [7:0]    act;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [CW-1:0] m_stall, m_flush;
   int            m_wd;

   pipeline_hazard_ctrl #(.STALL_LIMIT(LIMIT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
      .ex_branch_taken(ex_branch_taken), .ex_mc_busy(ex_mc_busy), .mem_busy(mem_busy),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .stall_timeout(stall_timeout),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   assign act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, ex_mem_flush};

   // Expected {pc,if_id,id_ex,ex_mem,mem_wb, f_if_id,f_id_ex,f_ex_mem} from the rules.
   function automatic logic [7:0] exp_outs();
      logic lu;
      lu = ex_is_load && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (rst)             return 8'b00000_000;
      if (mem_busy)        return 8'b00000_000;
      if (ex_mc_busy)      return 8'b00011_001;
      if (ex_branch_taken) return 8'b11111_110;
      if (lu)              return 8'b00111_010;
      return 8'b11111_000;
   endfunction

   task automatic idle_inputs();
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_is_load = 0; ex_branch_taken = 0; ex_mc_busy = 0; mem_busy = 0;
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic tick();
      logic [7:0] e;
      e = exp_outs();
      @(posedge clk);
      if (!rst) begin
         if (!e[7]) m_stall++;
         if (!mem_busy && !ex_mc_busy && ex_branch_taken) m_flush++;
         if (mem_busy || ex_mc_busy) m_wd++;
         else m_wd = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_stall = 0; m_flush = 0; m_wd = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_busy = 0; ex_mc_busy = 0; ex_branch_taken = 1; ex_is_load = 1;
      ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
      #1;
      total++; if (act !== 8'h00) begin bad++; $display("FAIL reset_outs act=%b req=%b", act, 8'h00); end
      total++; if (stall_cycles !== 0 || flush_count !== 0 || stall_timeout !== 0) begin
         bad++; $display("FAIL reset_cnt stall=%0d flush=%0d to=%b req=0", stall_cycles, flush_count, stall_timeout); end
      @(posedge clk); #1;
      total++; if (act !== 8'h00) begin bad++; $display("FAIL reset_hold act=%b req=%b", act, 8'h00); end
      rst = 1'b0; idle_inputs();
      m_stall = 0; m_flush = 0; m_wd = 0;
      #3;
      total++; if (act !== 8'b11111_000) begin bad++; $display("FAIL reset_run act=%b req=%b", act, 8'b11111_000); end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; id_rs2 = 9; id_uses_rs2 = 1;
      #3;
      total++; if (act !== 8'b00111_010 || act !== exp_outs()) begin
         bad++; $display("FAIL load_use act=%b req=%b", act, 8'b00111_010); end
      tick();
      ex_is_load = 0; ex_rd = 0;  // bubble now in EX
      #3;
      total++; if (act !== 8'b11111_000) begin bad++; $display("FAIL load_use_after act=%b req=%b", act, 8'b11111_000); end
      total++; if (stall_cycles !== 1) begin bad++; $display("FAIL load_use_stall got=%0d req=1", stall_cycles); end
      tick();
   endtask

   task automatic test_x0_unused();
      do_reset();
      ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
      #3;
      total++; if (act !== 8'b11111_000) begin bad++; $display("FAIL x0_no_stall act=%b req=%b", act, 8'b11111_000); end
      tick();
      ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 0;
      #3;
      total++; if (act !== 8'b11111_000) begin bad++; $display("FAIL unused_rs2 act=%b req=%b", act, 8'b11111_000); end
      tick();
      total++; if (stall_cycles !== 0) begin bad++; $display("FAIL x0_stall got=%0d req=0", stall_cycles); end
   endtask

   task automatic test_branch();
      do_reset();
      ex_branch_taken = 1;
      #3;
      total++; if (act !== 8'b11111_110) begin bad++; $display("FAIL branch act=%b req=%b", act, 8'b11111_110); end
      tick();
      total++; if (flush_count !== 1) begin bad++; $display("FAIL branch_cnt got=%0d req=1", flush_count); end
      ex_is_load = 1; ex_rd = 4; id_rs2 = 4; id_uses_rs2 = 1;
      #3;
      total++; if (act !== 8'b11111_110) begin bad++; $display("FAIL branch_over_lu act=%b req=%b", act, 8'b11111_110); end
      tick();
      total++; if (flush_count !== 2 || stall_cycles !== 0) begin
         bad++; $display("FAIL branch_cnt2 flush=%0d stall=%0d req=2/0", flush_count, stall_cycles); end
   endtask

   task automatic test_mem_branch();
      do_reset();
      mem_busy = 1; ex_branch_taken = 1;
      for (int k = 0; k < 3; k++) begin
         #3;
         total++; if (act !== 8'h00) begin bad++; $display("FAIL mem_freeze[%0d] act=%b req=%b", k, act, 8'h00); end
         tick();
      end
      total++; if (stall_cycles !== 3 || flush_count !== 0) begin
         bad++; $display("FAIL mem_freeze_cnt stall=%0d flush=%0d req=3/0", stall_cycles, flush_count); end
      mem_busy = 0;
      #3;
      total++; if (act !== 8'b11111_110) begin bad++; $display("FAIL mem_then_squash act=%b req=%b", act, 8'b11111_110); end
      tick();
      ex_branch_taken = 0;
      total++; if (flush_count !== 1 || stall_cycles !== 3) begin
         bad++; $display("FAIL mem_branch_cnt flush=%0d stall=%0d req=1/3", flush_count, stall_cycles); end
   endtask

   task automatic test_mem_mc_reset();
      do_reset();
      ex_branch_taken = 1;
      tick();
      ex_branch_taken = 0; mem_busy = 1; ex_mc_busy = 1;
      for (int k = 0; k < 2; k++) begin
         #3;
         total++; if (act !== 8'h00) begin bad++; $display("FAIL mc_freeze[%0d] act=%b req=%b", k, act, 8'h00); end
         tick();
      end
      mem_busy = 0;
      for (int k = 0; k < 4; k++) begin
         #3;
         total++; if (act !== 8'b00011_001) begin bad++; $display("FAIL ex_hold[%0d] act=%b req=%b", k, act, 8'b00011_001); end
         tick();
      end
      ex_mc_busy = 0;
      #3;
      total++; if (act !== 8'b11111_000) begin bad++; $display("FAIL hold_exit act=%b req=%b", act, 8'b11111_000); end
      tick();
      total++; if (stall_cycles !== 6 || flush_count !== 1) begin
         bad++; $display("FAIL mc_cnt stall=%0d flush=%0d req=6/1", stall_cycles, flush_count); end
      ex_mc_busy = 1;
      tick();
      #3;
      rst = 1'b1;  // asynchronous, away from any edge
      #1;
      total++; if (stall_cycles !== 0 || flush_count !== 0 || stall_timeout !== 0 || act !== 8'h00) begin
         bad++; $display("FAIL async_rst stall=%0d flush=%0d to=%b act=%b req=0", stall_cycles, flush_count, stall_timeout, act); end
      rst = 1'b0; ex_mc_busy = 0;
      m_stall = 0; m_flush = 0; m_wd = 0;
      #1;
      total++; if (act !== 8'b11111_000) begin bad++; $display("FAIL rst_to_run act=%b req=%b", act, 8'b11111_000); end
      tick();
   endtask

   task automatic test_watchdog();
      do_reset();
      mem_busy = 1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         total++; if (stall_timeout !== (k >= LIMIT)) begin
            bad++; $display("FAIL watchdog[%0d] got=%b req=%b", k, stall_timeout, (k >= LIMIT)); end
      end
      mem_busy = 0;
      tick();
      total++; if (stall_timeout !== 1'b0) begin bad++; $display("FAIL watchdog_clear got=%b req=0", stall_timeout); end
   endtask

   task automatic test_random();
      int burst;
      do_reset();
      burst = 0;
      for (int n = 0; n < 800; n++) begin
         if (burst == 0 && $urandom_range(0, 24) == 0) burst = $urandom_range(5, 14);
         mem_busy        = (burst > 0) || ($urandom_range(0, 5) == 0);
         if (burst > 0) burst--;
         ex_mc_busy      = ($urandom_range(0, 4) == 0);
         ex_branch_taken = ($urandom_range(0, 3) == 0);
         ex_is_load      = $urandom_range(0, 1);
         ex_rd           = 5'($urandom_range(0, 3));
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         id_uses_rs1     = $urandom_range(0, 1);
         id_uses_rs2     = $urandom_range(0, 1);
         #3;
         total++; if (act !== exp_outs()) begin
            bad++; $display("FAIL rand_outs[%0d] act=%b req=%b", n, act, exp_outs()); end
         tick();
         total++; if (stall_cycles !== m_stall || flush_count !== m_flush ||
                      stall_timeout !== (m_wd >= LIMIT)) begin
            bad++; $display("FAIL rand_regs[%0d] stall=%0d/%0d flush=%0d/%0d to=%b/%b", n,
                            stall_cycles, m_stall, flush_count, m_flush, stall_timeout, (m_wd >= LIMIT));
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      m_stall = 0; m_flush = 0; m_wd = 0;
      @(posedge clk); #1;
      test_reset();
      test_load_use();
      test_x0_unused();
      test_branch();
      test_mem_branch();
      test_mem_mc_reset();
      test_watchdog();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
